// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Purpose  : Shared definitions for the UART system-bus controllers (RX/TX):
//            register offsets, configuration reset values, receiver FSM state
//            encoding, error bit positions and the bit-period helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

  // Register byte offsets
  localparam logic [31:0] c_ADDR_DATA     = 32'h00;
  localparam logic [31:0] c_ADDR_VALID    = 32'h04;
  localparam logic [31:0] c_ADDR_BUSY     = 32'h08;
  localparam logic [31:0] c_ADDR_BAUD     = 32'h0C;
  localparam logic [31:0] c_ADDR_PARITY   = 32'h10;
  localparam logic [31:0] c_ADDR_STOPBIT  = 32'h14;
  localparam logic [31:0] c_ADDR_ERR      = 32'h18;
  localparam logic [31:0] c_ADDR_SOFT_RST = 32'h24;

  // Configuration reset values
  localparam logic [16:0] c_BAUD_RST    = 17'd9600;
  localparam logic        c_PARITY_RST  = 1'b1;
  localparam logic        c_STOPBIT_RST = 1'b1;

  // Error register bit positions
  localparam int c_ERR_PARITY = 0;
  localparam int c_ERR_FRAME  = 1;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4
  } rx_state_e;

  // Clock cycles per bit; a baudrate of 0 is treated as 1 to avoid div-by-0.
  function automatic logic [31:0] bit_period(input logic [31:0] clk_freq,
                                             input logic [16:0] baud);
    logic [31:0] w_div;
    w_div = (baud == 17'd0) ? 32'd1 : {15'd0, baud};
    return clk_freq / w_div;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx
// Purpose  : UART receiver core: 2-flop synchroniser, baud counter and
//            IDLE->START->DATA->PARITY->STOP state machine. Frame
//            configuration is captured at the start edge.
// Ports    : clk_i, rst          clock / synchronous active-high reset
//            rx_i                asynchronous serial input (idle high)
//            baudrate_i, parity_en_i, stopbit_i   live configuration
//            busy_o              frame in progress
//            rx_data_o, rx_valid_o                received byte + 1-cycle strobe
//            parity_err_o, frame_err_o            1-cycle error strobes
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 10_000_000
) (
  input  logic        clk_i,
  input  logic        rst,
  input  logic        rx_i,
  input  logic [16:0] baudrate_i,
  input  logic        parity_en_i,
  input  logic        stopbit_i,
  output logic        busy_o,
  output logic [7:0]  rx_data_o,
  output logic        rx_valid_o,
  output logic        parity_err_o,
  output logic        frame_err_o
);

  rx_state_e   r_state;
  logic        r_sync1, r_sync2, r_sync3;
  logic [31:0] r_cnt, r_period;
  logic        r_par_en, r_two_stop, r_stop_second;
  logic [2:0]  r_bitcnt;
  logic [7:0]  r_shift, r_data;
  logic        r_perr, r_ferr;
  logic        r_busy, r_valid, r_perr_p, r_ferr_p;

  logic [31:0] w_period, w_half_load, w_reload;
  logic        w_tick, w_ferr_now;

  assign w_period    = bit_period(CLK_FREQ, baudrate_i);
  // First sample lands half a bit after the start edge; clamp tiny periods.
  assign w_half_load = ((w_period >> 1) == 32'd0) ? 32'd0 : (w_period >> 1) - 32'd1;
  assign w_reload    = (r_period == 32'd0) ? 32'd0 : r_period - 32'd1;
  assign w_tick      = (r_cnt == 32'd0);
  assign w_ferr_now  = r_ferr | ~r_sync2;

  always_ff @(posedge clk_i) begin
    if (rst) begin
      r_state       <= RX_IDLE;
      r_sync1       <= 1'b1;
      r_sync2       <= 1'b1;
      r_sync3       <= 1'b1;
      r_cnt         <= 32'd0;
      r_period      <= 32'd0;
      r_par_en      <= c_PARITY_RST;
      r_two_stop    <= c_STOPBIT_RST;
      r_stop_second <= 1'b0;
      r_bitcnt      <= 3'd0;
      r_shift       <= 8'd0;
      r_data        <= 8'd0;
      r_perr        <= 1'b0;
      r_ferr        <= 1'b0;
      r_busy        <= 1'b0;
      r_valid       <= 1'b0;
      r_perr_p      <= 1'b0;
      r_ferr_p      <= 1'b0;
    end else begin
      r_sync1  <= rx_i;
      r_sync2  <= r_sync1;
      r_sync3  <= r_sync2;
      r_valid  <= 1'b0;
      r_perr_p <= 1'b0;
      r_ferr_p <= 1'b0;
      if (r_cnt != 32'd0) r_cnt <= r_cnt - 32'd1;

      case (r_state)
        RX_IDLE: begin
          if (r_sync3 && !r_sync2) begin
            r_state    <= RX_START;
            r_busy     <= 1'b1;
            r_period   <= w_period;
            r_par_en   <= parity_en_i;
            r_two_stop <= stopbit_i;
            r_cnt      <= w_half_load;
            r_perr     <= 1'b0;
            r_ferr     <= 1'b0;
          end
        end
        RX_START: begin
          if (w_tick) begin
            if (r_sync2) begin
              // Start bit vanished before mid-bit: treat as a glitch.
              r_state <= RX_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_state  <= RX_DATA;
              r_bitcnt <= 3'd0;
              r_cnt    <= w_reload;
            end
          end
        end
        RX_DATA: begin
          if (w_tick) begin
            r_shift  <= {r_sync2, r_shift[7:1]};
            r_bitcnt <= r_bitcnt + 3'd1;
            r_cnt    <= w_reload;
            if (r_bitcnt == 3'd7) begin
              r_state       <= r_par_en ? RX_PARITY : RX_STOP;
              r_stop_second <= 1'b0;
            end
          end
        end
        RX_PARITY: begin
          if (w_tick) begin
            if (r_sync2 != ^r_shift) r_perr <= 1'b1;
            r_state <= RX_STOP;
            r_cnt   <= w_reload;
          end
        end
        RX_STOP: begin
          if (w_tick) begin
            if (r_two_stop && !r_stop_second) begin
              r_stop_second <= 1'b1;
              r_ferr        <= w_ferr_now;
              r_cnt         <= w_reload;
            end else begin
              r_state <= RX_IDLE;
              r_busy  <= 1'b0;
              if (r_perr || w_ferr_now) begin
                r_perr_p <= r_perr;
                r_ferr_p <= w_ferr_now;
              end else begin
                r_data  <= r_shift;
                r_valid <= 1'b1;
              end
            end
          end
        end
        default: begin
          r_state <= RX_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o       = r_busy;
  assign rx_data_o    = r_data;
  assign rx_valid_o   = r_valid;
  assign parity_err_o = r_perr_p;
  assign frame_err_o  = r_ferr_p;

endmodule
`default_nettype wire

// File: rtl/uart_rx_sb_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_sb_ctrl
// Purpose  : System-bus slave around uart_rx: register decode, received-data
//            and sticky error registers, configuration, soft reset, interrupt.
// Macro    : UART_RX_IRQ_EN - when defined irq_o is raised the cycle after
//            valid rises and cleared by irq_ret_i or a data read; otherwise
//            irq_o is tied low and irq_ret_i is ignored.
// Ports    : clk_i, rst                     clock / sync active-high reset
//            addr_i, req_i, write_data_i, write_enable_i, read_data_o  bus
//            rx_i                           serial input from the pin
//            irq_o, irq_ret_i               interrupt request / acknowledge
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_sb_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 10_000_000
) (
  input  logic        clk_i,
  input  logic        rst,
  input  logic [31:0] addr_i,
  input  logic        req_i,
  input  logic [31:0] write_data_i,
  input  logic        write_enable_i,
  output logic [31:0] read_data_o,
  input  logic        rx_i,
  output logic        irq_o,
  input  logic        irq_ret_i
);

  logic [31:0] r_rdata;
  logic [7:0]  r_data;
  logic        r_valid;
  logic [16:0] r_baud;
  logic        r_parity_en, r_stopbit;
  logic [1:0]  r_err;

  logic        w_rd, w_wr, w_soft, w_rst, w_data_rd, w_err_rd;
  logic        w_busy, w_rx_valid, w_perr, w_ferr;
  logic [7:0]  w_rx_data;
  logic [1:0]  w_err_new;

  assign w_rd      = req_i & ~write_enable_i;
  assign w_wr      = req_i & write_enable_i;
  assign w_soft    = w_wr && (addr_i == c_ADDR_SOFT_RST) && (write_data_i == 32'd1);
  // Soft reset takes effect on the same edge that samples the write.
  assign w_rst     = rst | w_soft;
  assign w_data_rd = w_rd && (addr_i == c_ADDR_DATA);
  assign w_err_rd  = w_rd && (addr_i == c_ADDR_ERR);

  always_comb begin
    w_err_new               = 2'b00;
    w_err_new[c_ERR_PARITY] = w_perr;
    w_err_new[c_ERR_FRAME]  = w_ferr;
  end

  uart_rx #(.CLK_FREQ(CLK_FREQ)) u_rx (
    .clk_i        (clk_i),
    .rst          (w_rst),
    .rx_i         (rx_i),
    .baudrate_i   (r_baud),
    .parity_en_i  (r_parity_en),
    .stopbit_i    (r_stopbit),
    .busy_o       (w_busy),
    .rx_data_o    (w_rx_data),
    .rx_valid_o   (w_rx_valid),
    .parity_err_o (w_perr),
    .frame_err_o  (w_ferr)
  );

  always_ff @(posedge clk_i) begin
    if (w_rst) begin
      r_rdata     <= 32'd0;
      r_data      <= 8'd0;
      r_valid     <= 1'b0;
      r_baud      <= c_BAUD_RST;
      r_parity_en <= c_PARITY_RST;
      r_stopbit   <= c_STOPBIT_RST;
      r_err       <= 2'b00;
    end else begin
      r_rdata <= 32'd0;
      if (w_rd) begin
        case (addr_i)
          c_ADDR_DATA:    r_rdata <= {24'd0, r_data};
          c_ADDR_VALID:   r_rdata <= {31'd0, r_valid};
          c_ADDR_BUSY:    r_rdata <= {31'd0, w_busy};
          c_ADDR_BAUD:    r_rdata <= {15'd0, r_baud};
          c_ADDR_PARITY:  r_rdata <= {31'd0, r_parity_en};
          c_ADDR_STOPBIT: r_rdata <= {31'd0, r_stopbit};
          c_ADDR_ERR:     r_rdata <= {30'd0, r_err};
          default:        r_rdata <= 32'd0;
        endcase
      end

      // A new byte wins over a simultaneous data-read clear.
      if (w_rx_valid) begin
        r_data  <= w_rx_data;
        r_valid <= 1'b1;
      end else if (w_data_rd) begin
        r_valid <= 1'b0;
      end

      r_err <= (w_err_rd ? 2'b00 : r_err) | w_err_new;

      if (w_wr && !w_busy) begin
        case (addr_i)
          c_ADDR_BAUD:    r_baud      <= write_data_i[16:0];
          c_ADDR_PARITY:  r_parity_en <= write_data_i[0];
          c_ADDR_STOPBIT: r_stopbit   <= write_data_i[0];
          default: ;
        endcase
      end
    end
  end

  assign read_data_o = r_rdata;

`ifdef UART_RX_IRQ_EN
  logic r_irq, r_valid_d;

  always_ff @(posedge clk_i) begin
    if (w_rst) begin
      r_irq     <= 1'b0;
      r_valid_d <= 1'b0;
    end else begin
      r_valid_d <= r_valid;
      if (r_valid && !r_valid_d) r_irq <= 1'b1;
      else if (irq_ret_i || w_data_rd) r_irq <= 1'b0;
    end
  end

  assign irq_o = r_irq;
`else
  logic w_unused_irq_ret;
  assign w_unused_irq_ret = irq_ret_i;
  assign irq_o            = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_sb_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_sb_ctrl
// Purpose  : Self-checking bench for uart_rx_sb_ctrl at CLK_FREQ = 10 MHz.
//            Bytes sent on rx_i are queued and compared when read back.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_sb_ctrl;

  localparam int P9600   = 10_000_000 / 9600;    // 1041
  localparam int P115200 = 10_000_000 / 115200;  // 86

  logic        clk_i = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] addr_i = 32'd0;
  logic        req_i = 1'b0;
  logic [31:0] write_data_i = 32'd0;
  logic        write_enable_i = 1'b0;
  logic [31:0] read_data_o;
  logic        rx_i = 1'b1;
  logic        irq_o;
  logic        irq_ret_i = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] sb_q[$];

  uart_rx_sb_ctrl #(.CLK_FREQ(10_000_000)) dut (
    .clk_i          (clk_i),
    .rst            (rst),
    .addr_i         (addr_i),
    .req_i          (req_i),
    .write_data_i   (write_data_i),
    .write_enable_i (write_enable_i),
    .read_data_o    (read_data_o),
    .rx_i           (rx_i),
    .irq_o          (irq_o),
    .irq_ret_i      (irq_ret_i)
  );

  always #5 clk_i = ~clk_i;

  // Bus tasks are entered at a negedge and return at a negedge.
  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    addr_i = a; write_enable_i = 1'b0; req_i = 1'b1;
    @(negedge clk_i);
    req_i = 1'b0;
    d = read_data_o;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] v);
    addr_i = a; write_data_i = v; write_enable_i = 1'b1; req_i = 1'b1;
    @(negedge clk_i);
    req_i = 1'b0; write_enable_i = 1'b0;
  endtask

  task automatic hold_rx(input logic b, input int cycles);
    rx_i = b;
    repeat (cycles) @(negedge clk_i);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit par_en, input bit par_bad,
                            input int nstop, input bit stop_bad, input int period);
    hold_rx(1'b0, period);
    for (int i = 0; i < 8; i++) hold_rx(b[i], period);
    if (par_en) hold_rx((^b) ^ par_bad, period);
    for (int i = 0; i < nstop; i++) hold_rx(!(stop_bad && i == 0), period);
    hold_rx(1'b1, period);
  endtask

  task automatic test_reset();
    logic [31:0] v;
    rst = 1'b1;
    repeat (4) @(negedge clk_i);
    rst = 1'b0;
    n_cmp++; if (read_data_o !== 32'd0) begin n_bad++; $display("FAIL rst_rdata got %0d exp 0", read_data_o); end
    n_cmp++; if (irq_o !== 1'b0) begin n_bad++; $display("FAIL rst_irq got %0b exp 0", irq_o); end
    bus_read(32'h0C, v);
    n_cmp++; if (v !== 32'd9600) begin n_bad++; $display("FAIL rst_baud got %0d exp 9600", v); end
    bus_read(32'h10, v);
    n_cmp++; if (v !== 32'd1) begin n_bad++; $display("FAIL rst_parity got %0d exp 1", v); end
    bus_read(32'h14, v);
    n_cmp++; if (v !== 32'd1) begin n_bad++; $display("FAIL rst_stopbit got %0d exp 1", v); end
    bus_read(32'h04, v);
    n_cmp++; if (v !== 32'd0) begin n_bad++; $display("FAIL rst_valid got %0d exp 0", v); end
    bus_read(32'h08, v);
    n_cmp++; if (v !== 32'd0) begin n_bad++; $display("FAIL rst_busy got %0d exp 0", v); end
    bus_read(32'h18, v);
    n_cmp++; if (v !== 32'd0) begin n_bad++; $display("FAIL rst_err got %0d exp 0", v); end
  endtask

  task automatic test_good_frame();
    logic [31:0] v;
    logic [7:0] e;
    sb_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, 1'b0, 2, 1'b0, P9600);
    bus_read(32'h04, v);
    n_cmp++; if (v !== 32'd1) begin n_bad++; $display("FAIL a5_valid got %0d exp 1", v); end
`ifdef UART_RX_IRQ_EN
    n_cmp++; if (irq_o !== 1'b1) begin n_bad++; $display("FAIL a5_irq got %0b exp 1", irq_o); end
`else
    n_cmp++; if (irq_o !== 1'b0) begin n_bad++; $display("FAIL a5_irq got %0b exp 0", irq_o); end
`endif
    e = sb_q.pop_front();
    bus_read(32'h00, v);
    n_cmp++; if (v !== {24'd0, e}) begin n_bad++; $display("FAIL a5_data got %h exp %h", v, e); end
    bus_read(32'h04, v);
    n_cmp++; if (v !== 32'd0) begin n_bad++; $display("FAIL a5_valid_clr got %0d exp 0", v); end
    n_cmp++; if (irq_o !== 1'b0) begin n_bad++; $display("FAIL a5_irq_clr got %0b exp 0", irq_o); end
  endtask

  task automatic test_parity_err();
    logic [31:0] v;
    send_frame(8'h3C, 1'b1, 1'b1, 2, 1'b0, P9600);
    bus_read(32'h04, v);
    n_cmp++; if (v !== 32'd0) begin n_bad++; $display("FAIL perr_valid got %0d exp 0", v); end
    bus_read(32'h18, v);
    n_cmp++; if (v !== 32'd1) begin n_bad++; $display("FAIL perr_err got %0d exp 1", v); end
    bus_read(32'h18, v);
    n_cmp++; if (v !== 32'd0) begin n_bad++; $display("FAIL perr_err_clr got %0d exp 0", v); end
  endtask

  task automatic test_glitch();
    logic [31:0] v;
    hold_rx(1'b0, 100);
    bus_read(32'h08, v);
    n_cmp++; if (v !== 32'd1) begin n_bad++; $display("FAIL glitch_busy_mid got %0d exp 1", v); end
    hold_rx(1'b0, 99);
    hold_rx(1'b1, 600);
    bus_read(32'h08, v);
    n_cmp++; if (v !== 32'd0) begin n_bad++; $display("FAIL glitch_busy got %0d exp 0", v); end
    bus_read(32'h04, v);
    n_cmp++; if (v !== 32'd0) begin n_bad++; $display("FAIL glitch_valid got %0d exp 0", v); end
    bus_read(32'h18, v);
    n_cmp++; if (v !== 32'd0) begin n_bad++; $display("FAIL glitch_err got %0d exp 0", v); end
  endtask

  task automatic test_config_busy();
    logic [31:0] v;
    logic [7:0] e;
    sb_q.push_back(8'h11);
    fork
      send_frame(8'h11, 1'b1, 1'b0, 2, 1'b0, P9600);
      begin
        repeat (3000) @(negedge clk_i);
        bus_write(32'h0C, 32'd115200);
        bus_read(32'h0C, v);
        n_cmp++; if (v !== 32'd9600) begin n_bad++; $display("FAIL cfg_busy_baud got %0d exp 9600", v); end
      end
    join
    bus_read(32'h04, v);
    n_cmp++; if (v !== 32'd1) begin n_bad++; $display("FAIL cfg_11_valid got %0d exp 1", v); end
    e = sb_q.pop_front();
    bus_read(32'h00, v);
    n_cmp++; if (v !== {24'd0, e}) begin n_bad++; $display("FAIL cfg_11_data got %h exp %h", v, e); end
    bus_write(32'h0C, 32'd115200);
    bus_read(32'h0C, v);
    n_cmp++; if (v !== 32'd115200) begin n_bad++; $display("FAIL cfg_idle_baud got %0d exp 115200", v); end
    sb_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1, 1'b0, 2, 1'b0, P115200);
    bus_read(32'h04, v);
    n_cmp++; if (v !== 32'd1) begin n_bad++; $display("FAIL fast_5a_valid got %0d exp 1", v); end
    e = sb_q.pop_front();
    bus_read(32'h00, v);
    n_cmp++; if (v !== {24'd0, e}) begin n_bad++; $display("FAIL fast_5a_data got %h exp %h", v, e); end
  endtask

  task automatic test_frame_err();
    logic [31:0] v;
    send_frame(8'h81, 1'b1, 1'b0, 2, 1'b1, P115200);
    bus_read(32'h18, v);
    n_cmp++; if (v !== 32'd2) begin n_bad++; $display("FAIL ferr_err got %0d exp 2", v); end
    bus_read(32'h04, v);
    n_cmp++; if (v !== 32'd0) begin n_bad++; $display("FAIL ferr_valid got %0d exp 0", v); end
  endtask

  task automatic test_soft_reset();
    logic [31:0] v;
    logic [7:0] e;
    // Leave a byte unread so the soft reset has a valid flag to clear.
    send_frame(8'h77, 1'b1, 1'b0, 2, 1'b0, P115200);
    bus_read(32'h04, v);
    n_cmp++; if (v !== 32'd1) begin n_bad++; $display("FAIL srst_pre_valid got %0d exp 1", v); end
    bus_write(32'h10, 32'd0);
    hold_rx(1'b0, 400);
    rx_i = 1'b1;
    bus_write(32'h24, 32'd1);
    bus_read(32'h08, v);
    n_cmp++; if (v !== 32'd0) begin n_bad++; $display("FAIL srst_busy got %0d exp 0", v); end
    bus_read(32'h0C, v);
    n_cmp++; if (v !== 32'd9600) begin n_bad++; $display("FAIL srst_baud got %0d exp 9600", v); end
    bus_read(32'h10, v);
    n_cmp++; if (v !== 32'd1) begin n_bad++; $display("FAIL srst_parity got %0d exp 1", v); end
    bus_read(32'h04, v);
    n_cmp++; if (v !== 32'd0) begin n_bad++; $display("FAIL srst_valid got %0d exp 0", v); end
    sb_q.push_back(8'hC3);
    send_frame(8'hC3, 1'b1, 1'b0, 2, 1'b0, P9600);
    bus_read(32'h04, v);
    n_cmp++; if (v !== 32'd1) begin n_bad++; $display("FAIL srst_c3_valid got %0d exp 1", v); end
    e = sb_q.pop_front();
    bus_read(32'h00, v);
    n_cmp++; if (v !== {24'd0, e}) begin n_bad++; $display("FAIL srst_c3_data got %h exp %h", v, e); end
    n_cmp++; if (sb_q.size() != 0) begin n_bad++; $display("FAIL sb_left got %0d exp 0", sb_q.size()); end
  endtask

  initial begin
    @(negedge clk_i);
    test_reset();
    hold_rx(1'b1, 20);
    test_good_frame();
    test_parity_err();
    test_glitch();
    test_config_busy();
    test_frame_err();
    test_soft_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
